// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the cache word address,
// buffers fetched instructions in a 2-entry FIFO and handles branch
// redirects (including redirects that land during a line fill) and HALT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] i_addr,
    input  logic [15:0] instr,
    input  logic        instr_rdy,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus1,
    output logic        if_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        RUN,
        REDIR_WAIT,
        HALTED
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] redir_tgt;

    // Slot 0 is always the head; slot 1 holds the younger entry.
    logic [15:0] q_instr [2];
    logic [15:0] q_pc    [2];
    logic [1:0]  count;

    logic halt_seen;
    logic redir_pend;
    logic pop;
    logic push;
    logic push_halt;

    // HALTED and REDIR_WAIT are mutually exclusive, so both flags live
    // in the state register rather than in separate flops.
    assign halt_seen  = (state == HALTED);
    assign redir_pend = (state == REDIR_WAIT);

    assign pop       = (count != 2'd0) && !stall && !redirect;
    assign push      = instr_rdy && !halt_seen && !redir_pend && !redirect &&
                       ((count != 2'd2) || pop);
    assign push_halt = push && (instr[15:12] == HALT_OPCODE);

    // PC, pending redirect target and fetch state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            pc        <= RESET_PC;
            redir_tgt <= '0;
        end else if (redirect) begin
            if (instr_rdy) begin
                pc    <= redirect_pc;
                state <= RUN;
            end else begin
                // Miss in flight: i_addr must hold until the fill returns.
                redir_tgt <= redirect_pc;
                state     <= REDIR_WAIT;
            end
        end else begin
            case (state)
                RUN: begin
                    if (push) begin
                        pc <= pc + 16'd1;
                        if (push_halt) begin
                            state <= HALTED;
                        end
                    end
                end
                REDIR_WAIT: begin
                    // Fill for the stale address completes; drop it and retarget.
                    if (instr_rdy) begin
                        pc    <= redir_tgt;
                        state <= RUN;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Two-entry instruction FIFO; redirect flushes and cancels any pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (redirect) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    q_instr[count[0]] <= instr;
                    q_pc[count[0]]    <= pc;
                    count             <= count + 2'd1;
                end
                2'b01: begin
                    q_instr[0] <= q_instr[1];
                    q_pc[0]    <= q_pc[1];
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q_instr[0] <= instr;
                        q_pc[0]    <= pc;
                    end else begin
                        q_instr[0] <= q_instr[1];
                        q_pc[0]    <= q_pc[1];
                        q_instr[1] <= instr;
                        q_pc[1]    <= pc;
                    end
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

    // Outputs are decoded from registers only; payload is zeroed when invalid.
    always_comb begin
        i_addr      = pc;
        if_valid    = (count != 2'd0);
        halted      = halt_seen && (count == 2'd0) && !redir_pend;
        if_instr    = '0;
        if_pc       = '0;
        if_pc_plus1 = '0;
        if (if_valid) begin
            if_instr    = q_instr[0];
            if_pc       = q_pc[0];
            if_pc_plus1 = q_pc[0] + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a cycle table covering the directed scenarios,
// then a randomized hit/miss/stall stream checked against an expected-PC queue.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_addr;
    logic [15:0] instr;
    logic        instr_rdy;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus1;
    logic        if_valid;
    logic        halted;
    logic        hen;

    int tests = 0;
    int fails = 0;

    fetch_stage #(
        .RESET_PC   (16'h0000),
        .HALT_OPCODE(4'hF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_addr     (i_addr),
        .instr      (instr),
        .instr_rdy  (instr_rdy),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc_plus1(if_pc_plus1),
        .if_valid   (if_valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Cache model: word content derived from address; HALT at 0x0005 when enabled.
    function automatic logic [15:0] inst_of(input logic [15:0] a, input logic h);
        if (h && a == 16'h0005) return 16'hF000;
        return {4'h2, a[11:0] ^ {a[15:12], 8'h00}};
    endfunction

    // During a miss the bus carries a HALT-looking junk word that must never be taken.
    assign instr = instr_rdy ? inst_of(i_addr, hen) : 16'hF0F0;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        hen;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_pc;
        logic        e_halt;
    } vec_t;

    vec_t       vecs[$];
    logic [15:0] sb_q[$];

    task automatic add(input logic r, input logic rdy, input logic st, input logic rd,
                       input logic [15:0] rpc, input logic h, input logic [15:0] ea,
                       input logic ev, input logic [15:0] ep, input logic eh);
        vec_t v;
        v.rst_n = r; v.rdy = rdy; v.stall = st; v.redir = rd; v.rpc = rpc; v.hen = h;
        v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_halt = eh;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_instr;
        logic [15:0] exp_pc1;
        logic [15:0] prev_addr;
        logic        prev_rdy;
        int          cyc;

        // rst rdy st rd rpc h | addr v pc halt
        add(1,1,0,0,16'h0000,0, 16'h0000,0,16'h0000,0); // 0 reset state
        add(1,1,0,0,16'h0000,0, 16'h0001,1,16'h0000,0);
        add(1,1,0,0,16'h0000,0, 16'h0002,1,16'h0001,0);
        add(1,1,0,0,16'h0000,0, 16'h0003,1,16'h0002,0);
        add(1,0,0,0,16'h0000,0, 16'h0004,1,16'h0003,0); // 4 miss begins
        add(1,0,0,0,16'h0000,0, 16'h0004,0,16'h0000,0);
        add(1,0,0,0,16'h0000,0, 16'h0004,0,16'h0000,0);
        add(1,0,0,0,16'h0000,0, 16'h0004,0,16'h0000,0);
        add(1,1,0,0,16'h0000,0, 16'h0004,0,16'h0000,0); // 8 fill returns
        add(1,1,0,0,16'h0000,0, 16'h0005,1,16'h0004,0);
        add(1,1,0,1,16'h0010,0, 16'h0006,1,16'h0005,0); // 10 redirect 0x10
        add(1,1,0,0,16'h0000,0, 16'h0010,0,16'h0000,0);
        add(1,1,1,0,16'h0000,0, 16'h0011,1,16'h0010,0); // 12 stall x3
        add(1,1,1,0,16'h0000,0, 16'h0012,1,16'h0010,0);
        add(1,1,1,0,16'h0000,0, 16'h0012,1,16'h0010,0);
        add(1,1,0,0,16'h0000,0, 16'h0012,1,16'h0010,0); // 15 full FIFO push+pop
        add(1,1,0,1,16'h0040,0, 16'h0013,1,16'h0011,0); // 16 redirect with count=2
        add(1,1,0,0,16'h0000,0, 16'h0040,0,16'h0000,0);
        add(1,1,0,1,16'h0008,0, 16'h0041,1,16'h0040,0); // 18 go to 0x0008
        add(1,0,0,1,16'h0100,0, 16'h0008,0,16'h0000,0); // 19 redirect during miss
        add(1,0,0,0,16'h0000,0, 16'h0008,0,16'h0000,0);
        add(1,0,0,1,16'h0200,0, 16'h0008,0,16'h0000,0); // 21 overwrite target
        add(1,0,0,0,16'h0000,0, 16'h0008,0,16'h0000,0);
        add(1,1,0,0,16'h0000,0, 16'h0008,0,16'h0000,0); // 23 fill discarded
        add(1,1,0,0,16'h0000,0, 16'h0200,0,16'h0000,0);
        add(1,1,0,1,16'hFFFE,0, 16'h0201,1,16'h0200,0); // 25 redirect near wrap
        add(1,1,0,0,16'h0000,0, 16'hFFFE,0,16'h0000,0);
        add(1,1,0,0,16'h0000,0, 16'hFFFF,1,16'hFFFE,0);
        add(1,1,0,1,16'h0005,1, 16'h0000,1,16'hFFFF,0); // 28 wrapped; go to HALT
        add(1,1,0,0,16'h0000,1, 16'h0005,0,16'h0000,0);
        add(1,1,0,0,16'h0000,1, 16'h0006,1,16'h0005,0); // 30 HALT at head
        add(1,1,0,0,16'h0000,1, 16'h0006,0,16'h0000,1);
        add(1,1,0,1,16'h0000,1, 16'h0006,0,16'h0000,1); // 32 redirect out of HALT
        add(1,1,0,0,16'h0000,1, 16'h0000,0,16'h0000,0);
        add(1,1,0,1,16'h0005,1, 16'h0001,1,16'h0000,0);
        add(1,1,0,0,16'h0000,1, 16'h0005,0,16'h0000,0);
        add(1,1,0,0,16'h0000,1, 16'h0006,1,16'h0005,0);
        add(1,0,0,1,16'h0030,1, 16'h0006,0,16'h0000,1); // 37 redirect from HALT in miss
        add(1,0,0,0,16'h0000,1, 16'h0006,0,16'h0000,0);
        add(1,1,0,0,16'h0000,1, 16'h0006,0,16'h0000,0);
        add(1,1,0,0,16'h0000,1, 16'h0030,0,16'h0000,0);
        add(0,0,0,1,16'h0077,1, 16'h0031,1,16'h0030,0); // 41 reset mid-miss/redirect
        add(1,1,0,0,16'h0000,1, 16'h0000,0,16'h0000,0);
        add(1,1,0,0,16'h0000,1, 16'h0001,1,16'h0000,0);

        rst_n = 1'b0; instr_rdy = 1'b1; stall = 1'b0; redirect = 1'b0;
        redirect_pc = '0; hen = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            exp_instr = vecs[i].e_valid ? inst_of(vecs[i].e_pc, vecs[i].hen) : 16'h0000;
            exp_pc1   = vecs[i].e_valid ? vecs[i].e_pc + 16'd1 : 16'h0000;
            chk($sformatf("row%0d i_addr", i),   i_addr,            vecs[i].e_addr);
            chk($sformatf("row%0d if_valid", i), {15'd0, if_valid}, {15'd0, vecs[i].e_valid});
            chk($sformatf("row%0d if_pc", i),    if_pc,             vecs[i].e_valid ? vecs[i].e_pc : 16'h0000);
            chk($sformatf("row%0d if_instr", i), if_instr,          exp_instr);
            chk($sformatf("row%0d if_pc_plus1", i), if_pc_plus1,    exp_pc1);
            chk($sformatf("row%0d halted", i),   {15'd0, halted},   {15'd0, vecs[i].e_halt});
            rst_n       = vecs[i].rst_n;
            instr_rdy   = vecs[i].rdy;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            hen         = vecs[i].hen;
        end

        // Random hit/miss/stall stream from 0x0100: every PC delivered once, in order.
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0100; instr_rdy = 1'b1; stall = 1'b0; hen = 1'b0;
        for (int k = 0; k < 40; k++) sb_q.push_back(16'(16'h0100 + k));
        prev_rdy  = 1'b1;
        prev_addr = '0;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            redirect = 1'b0;
            if (!prev_rdy) chk("sb addr_hold_during_miss", i_addr, prev_addr);
            stall     = ($urandom_range(0, 2) == 0);
            instr_rdy = ($urandom_range(0, 3) != 0);
            if (if_valid && !stall) begin
                chk("sb if_pc", if_pc, sb_q[0]);
                chk("sb if_instr", if_instr, inst_of(sb_q[0], 1'b0));
                chk("sb if_pc_plus1", if_pc_plus1, sb_q[0] + 16'd1);
                void'(sb_q.pop_front());
            end
            prev_rdy  = instr_rdy;
            prev_addr = i_addr;
        end
        chk("sb drained", 16'(sb_q.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
